// File: rtl/ifft_reorder.sv
// rtl/ifft_reorder.sv - ping-pong frame buffer replaying N-sample frames in natural or bit-reversed order
module ifft_reorder #(
    parameter int W    = 28,
    parameter int LOGN = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pushin,
    input  logic [W-1:0] dir,
    input  logic [W-1:0] dii,
    input  logic         brev,
    input  logic         conj,
    output logic         pushout,
    output logic [W-1:0] dor,
    output logic [W-1:0] doi
);
    localparam int N = 1 << LOGN;

    typedef enum logic [1:0] {EMPTY, FILLING, DRAINING} bank_t;
    typedef enum logic {IDLE, DRAIN} rd_t;

    logic [2*W-1:0]  mem [0:2*N-1];
    bank_t           bstate [2];
    logic [1:0]      mbrev;
    logic [1:0]      mconj;
    logic [LOGN-1:0] wcnt;
    logic [LOGN-1:0] rcnt;
    logic            wsel;
    logic            rsel;
    rd_t             rstate;

    logic [LOGN-1:0] raddr;
    logic [2*W-1:0]  rword;
    logic [W-1:0]    rre;
    logic [W-1:0]    rim;
    logic [W-1:0]    rneg;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
        return r;
    endfunction

    always_comb begin
        raddr = mbrev[rsel] ? bitrev(rcnt) : rcnt;
        rword = mem[{rsel, raddr}];
        rre   = rword[2*W-1:W];
        rim   = rword[W-1:0];
        // the most negative value has no positive counterpart, so clamp it
        if (rim == {1'b1, {(W-1){1'b0}}})
            rneg = {1'b0, {(W-1){1'b1}}};
        else
            rneg = ~rim + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (pushin) mem[{wsel, wcnt}] <= {dir, dii};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pushout   <= 1'b0;
            dor       <= '0;
            doi       <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            rstate    <= IDLE;
            bstate[0] <= EMPTY;
            bstate[1] <= EMPTY;
            mbrev     <= '0;
            mconj     <= '0;
        end else begin
            case (rstate)
                IDLE: begin
                    pushout <= 1'b0;
                    rcnt    <= '0;
                    if (bstate[~wsel] == DRAINING) begin
                        rsel   <= ~wsel;
                        rstate <= DRAIN;
                    end
                end
                DRAIN: begin
                    pushout <= 1'b1;
                    dor     <= rre;
                    doi     <= mconj[rsel] ? rneg : rim;
                    rcnt    <= rcnt + LOGN'(1);
                    if (&rcnt) begin
                        bstate[rsel] <= EMPTY;
                        if (bstate[~rsel] == DRAINING)
                            rsel <= ~rsel;
                        else
                            rstate <= IDLE;
                    end
                end
                default: rstate <= IDLE;
            endcase

            // write side last so a new frame starting on a drain's final edge claims the bank
            if (pushin) begin
                wcnt <= wcnt + LOGN'(1);
                if (wcnt == '0) begin
                    bstate[wsel] <= FILLING;
                    mbrev[wsel]  <= brev;
                    mconj[wsel]  <= conj;
                end
                if (&wcnt) begin
                    bstate[wsel] <= DRAINING;
                    wsel         <= ~wsel;
                end
            end
        end
    end
endmodule
